// File: rtl/commit_mem_unit.sv
// Commit-time load/store engine: one non-speculative memory access per ROB head,
// with alignment/legality checks, lane steering, load extension and a response watchdog.
module commit_mem_unit #(
  parameter int unsigned MAX_WAIT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        data_mem_resp,
  input  logic [31:0] data_mem_rdata,
  output logic        data_read,
  output logic        data_write,
  output logic [3:0]  data_mbe,
  output logic [31:0] data_mem_address,
  output logic [31:0] data_mem_wdata,
  output logic [31:0] ld_data,
  output logic        done,
  output logic        fault,
  output logic        busy
);

  localparam int unsigned WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t          state;
  logic [WW-1:0]   wd_cnt;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;

  logic            legal;
  logic [3:0]      mbe_n;
  logic [31:0]     wrep_n;

  function automatic logic size_aligned(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'd0:    size_aligned = 1'b1;
      2'd1:    size_aligned = ~off[0];
      2'd2:    size_aligned = (off == 2'd0);
      default: size_aligned = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] rd);
    logic [31:0] b_sh;
    logic [31:0] h_sh;
    b_sh = rd >> {off, 3'b000};
    h_sh = rd >> {off[1], 4'b0000};
    case (f3)
      3'd0:    load_ext = {{24{b_sh[7]}}, b_sh[7:0]};
      3'd4:    load_ext = {24'd0, b_sh[7:0]};
      3'd1:    load_ext = {{16{h_sh[15]}}, h_sh[15:0]};
      3'd5:    load_ext = {16'd0, h_sh[15:0]};
      default: load_ext = rd;
    endcase
  endfunction

  // Legality is judged on the live inputs because they are latched on this same edge.
  always_comb begin
    legal  = 1'b0;
    mbe_n  = 4'b1111;
    wrep_n = wdata;
    if (req_read)
      legal = size_aligned(funct3[1:0], addr[1:0]) && !(funct3[2] && funct3[1]);
    else
      legal = size_aligned(funct3[1:0], addr[1:0]) && !funct3[2];
    case (funct3[1:0])
      2'd0: begin
        mbe_n  = 4'b0001 << addr[1:0];
        wrep_n = {4{wdata[7:0]}};
      end
      2'd1: begin
        mbe_n  = 4'b0011 << addr[1:0];
        wrep_n = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      wd_cnt           <= '0;
      f3_q             <= '0;
      off_q            <= '0;
      data_read        <= 1'b0;
      data_write       <= 1'b0;
      data_mbe         <= '0;
      data_mem_address <= '0;
      data_mem_wdata   <= '0;
      ld_data          <= '0;
      done             <= 1'b0;
      fault            <= 1'b0;
      busy             <= 1'b0;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      case (state)
        IDLE: begin
          if (req_read || req_write) begin
            busy   <= 1'b1;
            wd_cnt <= '0;
            f3_q   <= funct3;
            off_q  <= addr[1:0];
            if (!legal) begin
              state <= DONE;
              done  <= 1'b1;
              fault <= 1'b1;
              if (req_read) ld_data <= '0;
            end else begin
              data_mem_address <= {addr[31:2], 2'b00};
              if (req_read) begin
                state     <= READ;
                data_read <= 1'b1;
                data_mbe  <= '0;
              end else begin
                state          <= WRITE;
                data_write     <= 1'b1;
                data_mbe       <= mbe_n;
                data_mem_wdata <= wrep_n;
              end
            end
          end
        end
        READ, WRITE: begin
          if (data_mem_resp || wd_cnt == WD_LAST) begin
            state            <= DONE;
            done             <= 1'b1;
            fault            <= ~data_mem_resp;
            data_read        <= 1'b0;
            data_write       <= 1'b0;
            data_mbe         <= '0;
            data_mem_address <= '0;
            data_mem_wdata   <= '0;
            wd_cnt           <= '0;
            if (state == READ)
              ld_data <= data_mem_resp ? load_ext(f3_q, off_q, data_mem_rdata) : '0;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
